// File: rtl/usb_reg_fe_if.sv
// Bus bundle for usb_reg_fe: SAM3U parallel-bus pins on one side, register strobes on the other.
interface usb_reg_fe_if #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               I_usb_data;
  logic [pADDR_WIDTH-1:0]   I_usb_addr;
  logic                     I_usb_rdn;
  logic                     I_usb_wrn;
  logic                     I_usb_cen;
  logic [7:0]               O_usb_data;
  logic                     O_data_hs;
  logic [pADDR_WIDTH-1:0]   reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datao;
  logic [7:0]               reg_datai;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;
  logic                     O_proto_err;

  modport slave (
    input  I_usb_data, I_usb_addr, I_usb_rdn, I_usb_wrn, I_usb_cen, reg_datai,
    output O_usb_data, O_data_hs, reg_address, reg_bytecnt, reg_datao,
           reg_read, reg_write, reg_addrvalid, O_proto_err
  );

  modport master (
    output I_usb_data, I_usb_addr, I_usb_rdn, I_usb_wrn, I_usb_cen, reg_datai,
    input  O_usb_data, O_data_hs, reg_address, reg_bytecnt, reg_datao,
           reg_read, reg_write, reg_addrvalid, O_proto_err
  );
endinterface

// File: rtl/usb_reg_fe.sv
// SAM3U register-bus front end: samples bus pins on clk_usb and emits read/write strobes.
// Define USB_REG_SYNC2_EN to add a second pin-sampling flop (all pin latencies +1 cycle).
module usb_reg_fe #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic     clk_usb,
  input  logic     reset,
  usb_reg_fe_if.slave bus
);

  localparam int PW = pADDR_WIDTH + 11;
  localparam logic [PW-1:0] PINS_IDLE = {3'b111, {(PW-3){1'b0}}};
`ifdef USB_REG_SYNC2_EN
  localparam int SYNC_N = 2;
`else
  localparam int SYNC_N = 1;
`endif

  logic [PW-1:0]     pins_w;
  logic [PW-1:0]     pre_w;
  logic [PW-1:0]     samp_q;
  logic [SYNC_N-1:0] vld_q;

  assign pins_w = {bus.I_usb_cen, bus.I_usb_rdn, bus.I_usb_wrn, bus.I_usb_addr, bus.I_usb_data};

`ifdef USB_REG_SYNC2_EN
  logic [PW-1:0] meta_q;
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) meta_q <= PINS_IDLE;
    else       meta_q <= pins_w;
  end
  assign pre_w = meta_q;
`else
  assign pre_w = pins_w;
`endif

  // vld_q marks when samp_q holds real pin values rather than the reset image
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      samp_q <= PINS_IDLE;
      vld_q  <= '0;
    end else begin
      samp_q <= pre_w;
      vld_q  <= (vld_q << 1) | SYNC_N'(1);
    end
  end

  logic                   cen_s, rdn_s, wrn_s;
  logic [pADDR_WIDTH-1:0] addr_s;
  logic [7:0]             data_s;
  assign {cen_s, rdn_s, wrn_s, addr_s, data_s} = samp_q;

  logic                     rdn_dly_q, wrn_dly_q, armed_q;
  logic                     read_q, write_q, end_q, hs_q, err_q;
  logic [pADDR_WIDTH-1:0]   addr_q;
  logic [pBYTECNT_SIZE-1:0] cnt_q;
  logic [7:0]               datao_q, odata_q;

  logic                     armed_d, read_d, write_d, end_d, hs_d, err_d;
  logic [pADDR_WIDTH-1:0]   addr_d;
  logic [pBYTECNT_SIZE-1:0] cnt_d;
  logic [7:0]               datao_d, odata_d;
  logic                     sel, rd_fall, wr_fall, rd_rise, wr_rise, start, rd_active;

  // armed_q stays low after reset until both strobes are seen idle, so an
  // access caught in flight by reset is ignored until its next start edge
  always_comb begin
    sel       = armed_q & ~cen_s;
    rd_fall   = sel & ~rdn_s &  rdn_dly_q;
    wr_fall   = sel & ~wrn_s &  wrn_dly_q;
    rd_rise   = sel &  rdn_s & ~rdn_dly_q;
    wr_rise   = sel &  wrn_s & ~wrn_dly_q;
    start     = rd_fall | wr_fall;
    rd_active = armed_q & ~rdn_s & ~cen_s;

    armed_d = armed_q | (vld_q[SYNC_N-1] & rdn_s & wrn_s);
    read_d  = rd_fall & wrn_s;
    write_d = wr_rise;
    end_d   = rd_rise | wr_rise;

    addr_d = start ? addr_s : addr_q;
    cnt_d  = cnt_q;
    if (start && (addr_s != addr_q)) cnt_d = '0;
    else if (end_q)                  cnt_d = cnt_q + 1'b1;

    datao_d = wrn_s ? datao_q : data_s;
    odata_d = rd_active ? bus.reg_datai : odata_q;
    hs_d    = rd_active & wrn_s;
    err_d   = err_q | (~rdn_s & ~wrn_s);
  end

  // Edge-detect / strobe stage
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      rdn_dly_q <= 1'b1;
      wrn_dly_q <= 1'b1;
      armed_q   <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      end_q     <= 1'b0;
      hs_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      datao_q   <= '0;
      odata_q   <= '0;
    end else begin
      rdn_dly_q <= rdn_s;
      wrn_dly_q <= wrn_s;
      armed_q   <= armed_d;
      read_q    <= read_d;
      write_q   <= write_d;
      end_q     <= end_d;
      hs_q      <= hs_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      datao_q   <= datao_d;
      odata_q   <= odata_d;
    end
  end

  assign bus.O_usb_data    = odata_q;
  assign bus.O_data_hs     = hs_q;
  assign bus.reg_address   = addr_q;
  assign bus.reg_bytecnt   = cnt_q;
  assign bus.reg_datao     = datao_q;
  assign bus.reg_read      = read_q;
  assign bus.reg_write     = write_q;
  assign bus.reg_addrvalid = ~cen_s;
  assign bus.O_proto_err   = err_q;

endmodule

// File: tb/tb_usb_reg_fe.sv
// Bench for usb_reg_fe: scoreboard of expected strobes plus cycle-exact scenario checks.
`timescale 1ns/1ps
module tb_usb_reg_fe;
`ifdef USB_REG_SYNC2_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic clk_usb = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_usb = ~clk_usb;

  usb_reg_fe_if #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) bif  ();
  usb_reg_fe_if #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(4)) bif4 ();

  usb_reg_fe #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) dut  (.clk_usb(clk_usb), .reset(rst), .bus(bif));
  usb_reg_fe #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(4)) dut4 (.clk_usb(clk_usb), .reset(rst), .bus(bif4));

  logic       datai_mode  = 1'b0;
  logic [7:0] datai_const = 8'h00;
  logic       burst_en    = 1'b0;

  assign bif.reg_datai   = datai_mode ? {1'b0, bif.reg_bytecnt} : datai_const;
  assign bif4.reg_datai  = datai_mode ? {4'h0, bif4.reg_bytecnt} : datai_const;
  assign bif4.I_usb_data = bif.I_usb_data;
  assign bif4.I_usb_addr = bif.I_usb_addr;
  assign bif4.I_usb_rdn  = bif.I_usb_rdn;
  assign bif4.I_usb_wrn  = bif.I_usb_wrn;
  assign bif4.I_usb_cen  = bif.I_usb_cen;

  typedef struct packed {
    logic [7:0] a;
    logic [6:0] c;
    logic [7:0] d;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t rq4[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] m_addr = 8'h00;
  logic [6:0] m_cnt  = 7'd0;
  logic [7:0] m4_addr = 8'h00;
  logic [3:0] m4_cnt  = 4'd0;

  function automatic exp_t mk(input logic [7:0] a, input logic [6:0] c, input logic [7:0] d);
    exp_t e;
    e.a = a; e.c = c; e.d = d;
    return e;
  endfunction

  task automatic m_start(input logic [7:0] a);
    if (a != m_addr) m_cnt = 7'd0;
    m_addr = a;
    if (a != m4_addr) m4_cnt = 4'd0;
    m4_addr = a;
  endtask

  task automatic m_end();
    m_cnt  = m_cnt + 7'd1;
    m4_cnt = m4_cnt + 4'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_usb);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bif.I_usb_cen = 1'b0; bif.I_usb_addr = a; bif.I_usb_data = d;
    tick(1);
    bif.I_usb_wrn = 1'b0;
    m_start(a);
    wq.push_back(mk(a, m_cnt, d));
    tick(2);
    bif.I_usb_wrn = 1'b1;
    m_end();
    tick(1);
    bif.I_usb_cen = 1'b1;
    tick(3);
  endtask

  task automatic bus_read(input logic [7:0] a);
    bif.I_usb_cen = 1'b0; bif.I_usb_addr = a;
    tick(1);
    bif.I_usb_rdn = 1'b0;
    m_start(a);
    rq.push_back(mk(a, m_cnt, datai_mode ? {1'b0, m_cnt} : datai_const));
    if (burst_en) rq4.push_back(mk(a, {3'b000, m4_cnt}, {4'h0, m4_cnt}));
    tick(5 + XL);
    bif.I_usb_rdn = 1'b1;
    m_end();
    tick(1);
    bif.I_usb_cen = 1'b1;
    tick(3);
  endtask

  // Scoreboard monitor for the main DUT
  logic       rd_pend = 1'b0;
  logic [7:0] rd_exp  = 8'h00;
  always @(negedge clk_usb) begin
    exp_t e, o;
    if (rd_pend) begin
      total++;
      if (bif.O_usb_data !== rd_exp) begin
        bad++;
        $display("FAIL rd_data: got %02h want %02h", bif.O_usb_data, rd_exp);
      end
      rd_pend = 1'b0;
    end
    if (bif.reg_write !== 1'b0) begin
      total++;
      o = mk(bif.reg_address, bif.reg_bytecnt, bif.reg_datao);
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d cnt=%0d data=%02h want no write", o.a, o.c, o.d);
      end else begin
        e = wq.pop_front();
        if (o !== e)
          begin bad++; $display("FAIL write_sb: got addr=%0d cnt=%0d data=%02h want addr=%0d cnt=%0d data=%02h", o.a, o.c, o.d, e.a, e.c, e.d); end
      end
    end
    if (bif.reg_read !== 1'b0) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL read_unexpected: got read at addr=%0d cnt=%0d want no read", bif.reg_address, bif.reg_bytecnt);
      end else begin
        e = rq.pop_front();
        o = mk(bif.reg_address, bif.reg_bytecnt, e.d);
        if (o !== e)
          begin bad++; $display("FAIL read_sb: got addr=%0d cnt=%0d want addr=%0d cnt=%0d", o.a, o.c, e.a, e.c); end
        rd_exp  = e.d;
        rd_pend = 1'b1;
      end
    end
  end

  // Scoreboard monitor for the 4-bit byte-counter DUT (burst wrap)
  logic       rd4_pend = 1'b0;
  logic [7:0] rd4_exp  = 8'h00;
  always @(negedge clk_usb) begin
    exp_t e, o;
    if (rd4_pend) begin
      total++;
      if (bif4.O_usb_data !== rd4_exp) begin
        bad++;
        $display("FAIL rd4_data: got %02h want %02h", bif4.O_usb_data, rd4_exp);
      end
      rd4_pend = 1'b0;
    end
    if (burst_en && bif4.reg_read !== 1'b0) begin
      total++;
      if (rq4.size() == 0) begin
        bad++;
        $display("FAIL read4_unexpected: got cnt=%0d want no read", bif4.reg_bytecnt);
      end else begin
        e = rq4.pop_front();
        o = mk(bif4.reg_address, {3'b000, bif4.reg_bytecnt}, e.d);
        if (o !== e)
          begin bad++; $display("FAIL read4_sb: got addr=%0d cnt=%0d want addr=%0d cnt=%0d", o.a, o.c, e.a, e.c); end
        rd4_exp  = e.d;
        rd4_pend = 1'b1;
      end
    end
  end

  function automatic logic [41:0] outs();
    return {bif.O_usb_data, bif.O_data_hs, bif.reg_address, bif.reg_bytecnt, bif.reg_datao,
            bif.reg_read, bif.reg_write, bif.reg_addrvalid, bif.O_proto_err};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total++;
    if (outs() !== 42'd0) begin bad++; $display("FAIL reset_outputs: got %011h want 0", outs()); end
    rst = 1'b0;
    tick(3);
    total++;
    if (outs() !== 42'd0) begin bad++; $display("FAIL idle_after_reset: got %011h want 0", outs()); end
  endtask

  task automatic test_write_pair();
    bif.I_usb_cen = 1'b0; bif.I_usb_addr = 8'd1; bif.I_usb_data = 8'h08;
    tick(1);
    bif.I_usb_wrn = 1'b0;
    m_start(8'd1);
    wq.push_back(mk(8'd1, m_cnt, 8'h08));
    tick(2);
    bif.I_usb_wrn = 1'b1;
    m_end();
    @(negedge clk_usb);
    repeat (1 + XL) @(negedge clk_usb);
    total++;
    if (bif.reg_write !== 1'b0) begin bad++; $display("FAIL write_early: got %b want 0", bif.reg_write); end
    @(negedge clk_usb);
    total++;
    if (bif.reg_write !== 1'b1) begin bad++; $display("FAIL write_latency: got %b want 1", bif.reg_write); end
    tick(1);
    total++;
    if (bif.reg_bytecnt !== m_cnt) begin bad++; $display("FAIL bytecnt_update: got %0d want %0d", bif.reg_bytecnt, m_cnt); end
    bif.I_usb_cen = 1'b1;
    tick(3);
    bus_write(8'd1, 8'h48);
    total++;
    if ({bif.reg_address, bif.reg_datao, bif.reg_bytecnt} !== {8'd1, 8'h48, m_cnt})
      begin bad++; $display("FAIL write_pair_state: got addr=%0d data=%02h cnt=%0d want addr=1 data=48 cnt=%0d", bif.reg_address, bif.reg_datao, bif.reg_bytecnt, m_cnt); end
  endtask

  task automatic test_write_burst();
    logic [7:0] pat [10] = '{8'h41, 8'h01, 8'h00, 8'h11, 8'h10, 8'h01, 8'h00, 8'h11, 8'h10, 8'h41};
    for (int i = 0; i < 10; i++) bus_write(8'd60, pat[i]);
    total++;
    if (bif.reg_bytecnt !== 7'd10) begin bad++; $display("FAIL burst60_count: got %0d want 10", bif.reg_bytecnt); end
    bus_write(8'd4, 8'h5C);
    total++;
    if ({bif.reg_address, bif.reg_bytecnt} !== {8'd4, m_cnt})
      begin bad++; $display("FAIL addr_change: got addr=%0d cnt=%0d want addr=4 cnt=%0d", bif.reg_address, bif.reg_bytecnt, m_cnt); end
  endtask

  task automatic test_read_latency();
    datai_const = 8'hA5;
    bif.I_usb_cen = 1'b0; bif.I_usb_addr = 8'd4;
    tick(1);
    bif.I_usb_rdn = 1'b0;
    m_start(8'd4);
    rq.push_back(mk(8'd4, m_cnt, 8'hA5));
    @(negedge clk_usb);
    repeat (1 + XL) @(negedge clk_usb);
    total++;
    if (bif.reg_read !== 1'b0) begin bad++; $display("FAIL read_early: got %b want 0", bif.reg_read); end
    @(negedge clk_usb);
    total++;
    if (bif.reg_read !== 1'b1) begin bad++; $display("FAIL read_latency: got %b want 1", bif.reg_read); end
    @(negedge clk_usb);
    total++;
    if ({bif.O_data_hs, bif.O_usb_data} !== {1'b1, 8'hA5})
      begin bad++; $display("FAIL read_pins: got hs=%b data=%02h want hs=1 data=a5", bif.O_data_hs, bif.O_usb_data); end
    tick(2);
    bif.I_usb_rdn = 1'b1;
    m_end();
    @(negedge clk_usb);
    repeat (1 + XL) @(negedge clk_usb);
    total++;
    if (bif.O_data_hs !== 1'b1) begin bad++; $display("FAIL hs_hold: got %b want 1", bif.O_data_hs); end
    @(negedge clk_usb);
    total++;
    if (bif.O_data_hs !== 1'b0) begin bad++; $display("FAIL hs_fall: got %b want 0", bif.O_data_hs); end
    tick(1);
    bif.I_usb_cen = 1'b1;
    tick(3);
  endtask

  task automatic test_burst_read();
    datai_mode = 1'b1;
    burst_en   = 1'b1;
    for (int k = 0; k < 20; k++) bus_read(8'd3);
    total++;
    if ({bif.reg_bytecnt, bif4.reg_bytecnt} !== {7'd20, 4'd4})
      begin bad++; $display("FAIL burst_count: got %0d/%0d want 20/4", bif.reg_bytecnt, bif4.reg_bytecnt); end
    burst_en   = 1'b0;
    datai_mode = 1'b0;
  endtask

  task automatic test_proto_err();
    bif.I_usb_cen = 1'b0; bif.I_usb_addr = 8'd2; bif.I_usb_data = 8'h5A;
    tick(1);
    total++;
    if (bif.O_proto_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", bif.O_proto_err); end
    bif.I_usb_rdn = 1'b0; bif.I_usb_wrn = 1'b0;
    m_start(8'd2);
    wq.push_back(mk(8'd2, m_cnt, 8'h5A));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_usb);
      total++;
      if (bif.O_data_hs !== 1'b0) begin bad++; $display("FAIL proto_hs: got %b want 0", bif.O_data_hs); end
    end
    tick(1);
    bif.I_usb_rdn = 1'b1; bif.I_usb_wrn = 1'b1;
    m_end();
    tick(1);
    bif.I_usb_cen = 1'b1;
    tick(3);
    total++;
    if (bif.O_proto_err !== 1'b1) begin bad++; $display("FAIL proto_err: got %b want 1", bif.O_proto_err); end
    bus_write(8'd2, 8'h11);
    total++;
    if (bif.O_proto_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bif.O_proto_err); end
  endtask

  task automatic test_reset_mid_read();
    datai_const = 8'h3C;
    bif.I_usb_cen = 1'b0; bif.I_usb_addr = 8'd5;
    tick(1);
    bif.I_usb_rdn = 1'b0;
    m_start(8'd5);
    rq.push_back(mk(8'd5, m_cnt, 8'h3C));
    tick(4 + XL);
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 42'd0) begin bad++; $display("FAIL reset_mid: got %011h want 0", outs()); end
    m_addr = 8'h00; m_cnt = 7'd0; m4_addr = 8'h00; m4_cnt = 4'd0;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_usb);
      total++;
      if (bif.O_data_hs !== 1'b0) begin bad++; $display("FAIL hs_after_reset: got %b want 0", bif.O_data_hs); end
    end
    tick(1);
    bif.I_usb_rdn = 1'b1;
    tick(2);
    bif.I_usb_rdn = 1'b0;
    m_start(8'd5);
    rq.push_back(mk(8'd5, m_cnt, 8'h3C));
    tick(5 + XL);
    bif.I_usb_rdn = 1'b1;
    m_end();
    tick(1);
    bif.I_usb_cen = 1'b1;
    tick(3);
    total++;
    if ({bif.reg_address, bif.reg_bytecnt} !== {8'd5, m_cnt})
      begin bad++; $display("FAIL reread_state: got addr=%0d cnt=%0d want addr=5 cnt=%0d", bif.reg_address, bif.reg_bytecnt, m_cnt); end
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    while ((wq.size() != 0 || rq.size() != 0 || rq4.size() != 0) && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (wq.size() != 0 || rq.size() != 0 || rq4.size() != 0)
      begin bad++; $display("FAIL drain: got pending w=%0d r=%0d r4=%0d want 0", wq.size(), rq.size(), rq4.size()); end
  endtask

  initial begin
    bif.I_usb_cen = 1'b1; bif.I_usb_rdn = 1'b1; bif.I_usb_wrn = 1'b1;
    bif.I_usb_addr = 8'h00; bif.I_usb_data = 8'h00;
    test_reset();
    test_write_pair();
    test_write_burst();
    test_read_latency();
    test_burst_read();
    test_proto_err();
    test_reset_mid_read();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
